// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: immediate-format selects, base opcodes and
// the fetch FSM state encoding.
package riscv_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_U = 3'b010,
    IMM_B = 3'b101,
    IMM_J = 3'b110
  } immsrc_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2,
    S_HOLD  = 2'd3
  } fe_state_t;

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory bus and IF/ID slot bus. master = the producing side
// (fetch stage drives requests and the slot), slave = memory / consumer.
interface imem_if #(parameter int XLEN = 32);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (output imem_req_valid, imem_req_addr,
                  input  imem_req_ready, imem_rsp_valid, imem_rsp_data);
  modport slave  (input  imem_req_valid, imem_req_addr,
                  output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

interface id_if import riscv_pkg::*; #(parameter int XLEN = 32);
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-8:0] id_imm;
  immsrc_t         id_immsrc;
  logic            id_illegal;

  modport master (output id_valid, id_pc, id_instr, id_imm, id_immsrc, id_illegal,
                  input  id_ready);
  modport slave  (input  id_valid, id_pc, id_instr, id_imm, id_immsrc, id_illegal,
                  output id_ready);
endinterface

// File: rtl/imm_src_decoder.sv
// Opcode -> immediate format select. R-type has no immediate but is legal;
// anything unrecognised falls back to IMM_I and raises illegal.
module imm_src_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output immsrc_t    immsrc,
  output logic       illegal
);

  always_comb begin
    immsrc  = IMM_I;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_OP: immsrc = IMM_I;
      OPC_STORE:                             immsrc = IMM_S;
      OPC_LUI, OPC_AUIPC:                    immsrc = IMM_U;
      OPC_BRANCH:                            immsrc = IMM_B;
      OPC_JAL:                               immsrc = IMM_J;
      default:                               illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch/decode front-end: one outstanding imem request, registered IF/ID slot,
// opcode decode registered alongside the instruction word.
module if_id_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_if.master          imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  id_if.master            id
);

  fe_state_t       state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_tgt;
  logic            id_valid_q;
  logic [XLEN-1:0] id_pc_q;
  logic [XLEN-1:0] id_instr_q;
  immsrc_t         id_immsrc_q;
  logic            id_illegal_q;
  immsrc_t         dec_immsrc;
  logic            dec_illegal;

  imm_src_decoder u_dec (
    .opcode  (imem.imem_rsp_data[6:0]),
    .immsrc  (dec_immsrc),
    .illegal (dec_illegal)
  );

  assign redirect_tgt = redirect_pc & ~(XLEN'(3));

  // A redirect suppresses the request in the same cycle so the new PC is used.
  assign imem.imem_req_valid = (state == S_FETCH) && !redirect_valid;
  assign imem.imem_req_addr  = pc;

  assign id.id_valid   = id_valid_q;
  assign id.id_pc      = id_pc_q;
  assign id.id_instr   = id_instr_q;
  assign id.id_imm     = id_instr_q[XLEN-1:7];
  assign id.id_immsrc  = id_immsrc_q;
  assign id.id_illegal = id_illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= NOP;
      id_immsrc_q  <= IMM_I;
      id_illegal_q <= 1'b0;
    end else if (redirect_valid) begin
      pc         <= redirect_tgt;
      id_valid_q <= 1'b0;
      // An in-flight request must still be drained; its word is stale.
      if ((state == S_WAIT || state == S_DROP) && !imem.imem_rsp_valid)
        state <= S_DROP;
      else
        state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: if (imem.imem_req_ready) state <= S_WAIT;
        S_WAIT: begin
          if (imem.imem_rsp_valid) begin
            id_valid_q   <= 1'b1;
            id_pc_q      <= pc;
            id_instr_q   <= imem.imem_rsp_data;
            id_immsrc_q  <= dec_immsrc;
            id_illegal_q <= dec_illegal;
            pc           <= pc + XLEN'(4);
            state        <= S_HOLD;
          end
        end
        S_DROP: if (imem.imem_rsp_valid) state <= S_FETCH;
        S_HOLD: begin
          if (id.id_ready) begin
            id_valid_q <= 1'b0;
            state      <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed table of decode vectors, multi-cycle corner
// sequences, then randomized traffic against a transaction-level model.
module tb_if_id_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_if #(.XLEN(32)) im0();
  id_if   #(.XLEN(32)) id0();
  imem_if #(.XLEN(32)) im1();
  id_if   #(.XLEN(32)) id1();
  logic        rv0, rv1;
  logic [31:0] rpc0, rpc1;

  if_id_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) u0 (
    .clk(clk), .rst_n(rst_n), .imem(im0), .redirect_valid(rv0), .redirect_pc(rpc0), .id(id0));
  if_id_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst_n(rst_n), .imem(im1), .redirect_valid(rv1), .redirect_pc(rpc1), .id(id1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // {illegal, immsrc} straight from the opcode table
  function automatic logic [3:0] ref_dec(input logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h33: return 4'b0000;
      7'h23:                      return 4'b0001;
      7'h37, 7'h17:               return 4'b0010;
      7'h63:                      return 4'b0101;
      7'h6F:                      return 4'b0110;
      default:                    return 4'b1000;
    endcase
  endfunction

  logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h33, 7'h7F};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    return {r[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  typedef struct {
    logic [31:0] w;
    logic [2:0]  src;
    logic        ill;
  } vec_t;
  vec_t tbl [9];

  task automatic issue(input logic [31:0] w, output logic [31:0] addr);
    int n = 0;
    while (!im0.imem_req_valid && n < 20) begin @(negedge clk); n++; end
    chk("req_valid_seen", im0.imem_req_valid, 1);
    addr = im0.imem_req_addr;
    im0.imem_req_ready = 1'b1;
    @(negedge clk);
    im0.imem_req_ready = 1'b0;
    im0.imem_rsp_valid = 1'b1;
    im0.imem_rsp_data  = w;
    @(negedge clk);
    im0.imem_rsp_valid = 1'b0;
  endtask

  task automatic check_slot(input string nm, input logic [31:0] pc, input logic [31:0] w,
                            input logic [2:0] src, input logic ill, input logic [24:0] imm);
    chk({nm, ".valid"},   id0.id_valid, 1);
    chk({nm, ".pc"},      id0.id_pc, pc);
    chk({nm, ".instr"},   id0.id_instr, w);
    chk({nm, ".imm"},     id0.id_imm, imm);
    chk({nm, ".immsrc"},  id0.id_immsrc, src);
    chk({nm, ".illegal"}, id0.id_illegal, ill);
  endtask

  task automatic consume();
    id0.id_ready = 1'b1;
    @(negedge clk);
    id0.id_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, exp_a;
    logic        redir, rsp, exp_rv, outstanding, flush, slot_full;
    logic [31:0] exp_pc, out_addr, slot_pc, slot_w;
    logic [3:0]  d;
    int          cnt, delivered;

    tbl[0] = '{32'h0011_2623, 3'b001, 1'b0};
    tbl[1] = '{32'h0020_8463, 3'b101, 1'b0};
    tbl[2] = '{32'h0080_00EF, 3'b110, 1'b0};
    tbl[3] = '{32'h1234_50B7, 3'b010, 1'b0};
    tbl[4] = '{32'hFFFF_FFFF, 3'b000, 1'b1};
    tbl[5] = '{32'h0000_0033, 3'b000, 1'b0};
    tbl[6] = '{32'h0000_2003, 3'b000, 1'b0};
    tbl[7] = '{32'h0000_0017, 3'b010, 1'b0};
    tbl[8] = '{32'h0000_000B, 3'b000, 1'b1};

    im0.imem_req_ready = 0; im0.imem_rsp_valid = 0; im0.imem_rsp_data = 0;
    im1.imem_req_ready = 0; im1.imem_rsp_valid = 0; im1.imem_rsp_data = 0;
    id0.id_ready = 0; id1.id_ready = 0;
    rv0 = 0; rv1 = 0; rpc0 = 0; rpc1 = 0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst.id_valid",   id0.id_valid, 0);
    chk("rst.id_pc",      id0.id_pc, 0);
    chk("rst.id_instr",   id0.id_instr, 32'h13);
    chk("rst.id_imm",     id0.id_imm, 0);
    chk("rst.id_immsrc",  id0.id_immsrc, 0);
    chk("rst.id_illegal", id0.id_illegal, 0);
    chk("rst.req_addr",   im0.imem_req_addr, 0);
    chk("rst.req_valid",  im0.imem_req_valid, 1);
    chk("rst.u1_addr",    im1.imem_req_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // first fetch
    issue(32'h0050_0093, a);
    chk("t1.addr", a, 0);
    check_slot("t1", 32'h0, 32'h0050_0093, 3'b000, 1'b0, 25'h000A001);
    consume();
    chk("t1.next_addr",  im0.imem_req_addr, 4);
    chk("t1.next_valid", im0.imem_req_valid, 1);

    // decode table
    exp_a = 32'h4;
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].w, a);
      chk("tbl.addr", a, exp_a);
      check_slot("tbl", exp_a, tbl[i].w, tbl[i].src, tbl[i].ill, tbl[i].w[31:7]);
      consume();
      exp_a += 4;
    end

    // consumer stall: slot stable, no new request, stray response ignored
    issue(32'h00A0_0113, a);
    chk("stall.addr", a, exp_a);
    for (int k = 0; k < 5; k++) begin
      im0.imem_rsp_valid = (k == 2);
      im0.imem_rsp_data  = 32'hFFFF_FFFF;
      chk("stall.id_valid",  id0.id_valid, 1);
      chk("stall.id_instr",  id0.id_instr, 32'h00A0_0113);
      chk("stall.id_pc",     id0.id_pc, exp_a);
      chk("stall.req_valid", im0.imem_req_valid, 0);
      @(negedge clk);
    end
    im0.imem_rsp_valid = 1'b0;
    consume();
    exp_a += 4;

    // redirect while waiting: word dropped, target word-aligned
    chk("redir.addr", im0.imem_req_addr, exp_a);
    im0.imem_req_ready = 1'b1;
    @(negedge clk);
    im0.imem_req_ready = 1'b0;
    rv0 = 1'b1; rpc0 = 32'h103;
    chk("redir.req_valid_wait", im0.imem_req_valid, 0);
    @(negedge clk);
    rv0 = 1'b0;
    im0.imem_rsp_valid = 1'b1; im0.imem_rsp_data = 32'h0050_0093;
    chk("redir.id_valid_drop", id0.id_valid, 0);
    chk("redir.req_valid_drop", im0.imem_req_valid, 0);
    @(negedge clk);
    im0.imem_rsp_valid = 1'b0;
    chk("redir.id_valid", id0.id_valid, 0);
    chk("redir.req_valid", im0.imem_req_valid, 1);
    chk("redir.req_addr", im0.imem_req_addr, 32'h100);

    // randomized traffic against a transaction-level model
    outstanding = 0; flush = 0; slot_full = 0; exp_pc = 32'h100;
    out_addr = 0; slot_pc = 0; slot_w = 0; cnt = 0; delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      redir = ($urandom_range(0, 11) == 0);
      rv0   = redir;
      rpc0  = $urandom;
      im0.imem_req_ready = ($urandom_range(0, 9) < 6);
      id0.id_ready       = ($urandom_range(0, 9) < 7);
      rsp = 1'b0;
      if (outstanding) begin
        if (cnt == 0) rsp = 1'b1;
        else cnt--;
      end else begin
        rsp = ($urandom_range(0, 7) == 0);
      end
      im0.imem_rsp_valid = rsp;
      im0.imem_rsp_data  = rand_instr();
      #1;
      exp_rv = !outstanding && !slot_full && !redir;
      chk("rnd.req_valid", im0.imem_req_valid, exp_rv);
      chk("rnd.req_addr",  im0.imem_req_addr, exp_pc);
      chk("rnd.id_valid",  id0.id_valid, slot_full);
      if (slot_full) begin
        d = ref_dec(slot_w);
        chk("rnd.id_pc",      id0.id_pc, slot_pc);
        chk("rnd.id_instr",   id0.id_instr, slot_w);
        chk("rnd.id_imm",     id0.id_imm, slot_w[31:7]);
        chk("rnd.id_immsrc",  id0.id_immsrc, d[2:0]);
        chk("rnd.id_illegal", id0.id_illegal, d[3]);
      end
      if (redir) begin
        exp_pc = rpc0 & ~32'h3;
        if (slot_full && id0.id_ready) delivered++;
        slot_full = 0;
        if (outstanding) begin
          if (rsp) begin outstanding = 0; flush = 0; end
          else flush = 1;
        end
      end else if (exp_rv && im0.imem_req_ready) begin
        outstanding = 1; flush = 0; out_addr = exp_pc; cnt = $urandom_range(0, 2);
      end else if (outstanding && rsp) begin
        outstanding = 0;
        if (!flush) begin
          slot_full = 1; slot_pc = out_addr; slot_w = im0.imem_rsp_data; exp_pc = out_addr + 4;
        end
        flush = 0;
      end else if (slot_full && id0.id_ready) begin
        slot_full = 0;
        delivered++;
      end
      @(negedge clk);
    end
    rv0 = 0; im0.imem_req_ready = 0; im0.imem_rsp_valid = 0; id0.id_ready = 0;
    chk("rnd.progress", delivered > 50, 1);

    // clean reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // PC wraps past the top of the address space
    chk("wrap.first_addr", im1.imem_req_addr, 32'hFFFF_FFFC);
    im1.imem_req_ready = 1'b1;
    @(negedge clk);
    im1.imem_req_ready = 1'b0;
    im1.imem_rsp_valid = 1'b1; im1.imem_rsp_data = 32'h13;
    @(negedge clk);
    im1.imem_rsp_valid = 1'b0;
    chk("wrap.id_valid", id1.id_valid, 1);
    chk("wrap.id_pc",    id1.id_pc, 32'hFFFF_FFFC);
    id1.id_ready = 1'b1;
    @(negedge clk);
    id1.id_ready = 1'b0;
    chk("wrap.second_addr", im1.imem_req_addr, 0);
    chk("wrap.req_valid",   im1.imem_req_valid, 1);

    // reset asserted mid-WAIT, late response afterwards
    issue(32'h0050_0093, a);
    consume();
    issue(32'h0011_2623, a);
    consume();
    chk("mid.addr", im0.imem_req_addr, 8);
    im0.imem_req_ready = 1'b1;
    @(negedge clk);
    im0.imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid.rst_id_valid",  id0.id_valid, 0);
    chk("mid.rst_id_pc",     id0.id_pc, 0);
    chk("mid.rst_id_instr",  id0.id_instr, 32'h13);
    chk("mid.rst_id_imm",    id0.id_imm, 0);
    chk("mid.rst_immsrc",    id0.id_immsrc, 0);
    chk("mid.rst_illegal",   id0.id_illegal, 0);
    chk("mid.rst_req_addr",  im0.imem_req_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    im0.imem_rsp_valid = 1'b1; im0.imem_rsp_data = 32'h0011_2623;
    @(negedge clk);
    im0.imem_rsp_valid = 1'b0;
    chk("late.id_valid",  id0.id_valid, 0);
    chk("late.id_instr",  id0.id_instr, 32'h13);
    chk("late.req_valid", im0.imem_req_valid, 1);
    chk("late.req_addr",  im0.imem_req_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
